// File: rtl/i2s_ctrl_pkg.sv
// i2s_ctrl_pkg: shared state encoding and reset defaults for the I2S stream controller
package i2s_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, PRIME, RUN, STOP, QUIESCE} ctrl_state_t;
    localparam logic [5:0] RES_DEFAULT = 6'd16;
    localparam logic [9:0] DIV_DEFAULT = 10'd4;
    localparam logic [7:0] UNDERRUN_MAX = 8'd255;
endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: synchronous FIFO with registered full/empty flags and a flush
module i2s_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count_n;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    assign count_n = flush ? '0 :
                     (do_push && !do_pop) ? count + 1'b1 :
                     (!do_push && do_pop) ? count - 1'b1 : count;
    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= flush ? '0 : do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= flush ? '0 : do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count_n;
            full   <= count_n == (AW+1)'(DEPTH);
            empty  <= count_n == '0;
        end
    end
endmodule

// File: rtl/i2s_stream_ctrl.sv
// i2s_stream_ctrl: sequences the lscc_i2s_codec master and feeds/collects its samples
module i2s_stream_ctrl
    import i2s_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int TRANSCEIVER_MODE = 0,
    parameter int FIFO_DEPTH       = 4,
    parameter int PRIME_LEVEL      = 2,
    parameter int QUIESCE_CYCLES   = 8
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        cfg_wr,
    input  logic [5:0]  cfg_res,
    input  logic [9:0]  cfg_div,
    input  logic        cfg_swap,
    output logic        cfg_err,
    input  logic        start,
    input  logic        stop,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [31:0] rx_data,
    output logic        rx_chan,
    output logic        busy,
    output logic [7:0]  underrun_cnt,
    output logic [5:0]  codec_sampleres,
    output logic [9:0]  codec_clkdiv,
    output logic        codec_sampleorder,
    output logic        codec_enabler,
    output logic [31:0] codec_i2din,
    input  logic        codec_buffer,
    input  logic [31:0] codec_i2dout,
    input  logic        codec_lrclk
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int QW = $clog2(QUIESCE_CYCLES + 1);
    localparam bit TX = (TRANSCEIVER_MODE == 0);
    ctrl_state_t state, next;
    logic [CW-1:0] count;
    logic [QW-1:0] qcnt;
    logic [DATA_WIDTH-1:0] head;
    logic full, empty, word, push, pop, flush, enabler_d, busy_d;
    logic unused_bits;
    assign unused_bits = ^{tx_data, codec_i2dout};
    // a word boundary is a codec buffer pulse while the codec is enabled
    assign word = codec_buffer && (state == RUN || state == STOP);
    assign pop = word && TX;
    assign tx_ready = TX && (state == PRIME || state == RUN) && !full;
    assign push = tx_valid && tx_ready;
    assign flush = state == QUIESCE || (state == PRIME && stop);
    i2s_tx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .sysclk(sysclk), .reset(reset), .push(push), .pop(pop), .flush(flush),
        .din(tx_data[DATA_WIDTH-1:0]), .dout(head), .full(full), .empty(empty), .count(count)
    );
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state <= IDLE;
            qcnt  <= '0;
        end else begin
            state <= next;
            qcnt  <= state == QUIESCE ? qcnt + 1'b1 : '0;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = stop ? IDLE : start ? (TX ? PRIME : RUN) : IDLE;
            PRIME:   next = stop ? IDLE : count >= CW'(PRIME_LEVEL) ? RUN : PRIME;
            RUN:     next = stop ? STOP : RUN;
            STOP:    next = codec_buffer ? QUIESCE : STOP;
            QUIESCE: next = qcnt == QW'(QUIESCE_CYCLES - 1) ? IDLE : QUIESCE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        enabler_d = next == RUN || next == STOP;
        busy_d = next != IDLE;
    end
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            codec_enabler     <= 1'b0;
            busy              <= 1'b0;
            cfg_err           <= 1'b0;
            codec_sampleres   <= RES_DEFAULT;
            codec_clkdiv      <= DIV_DEFAULT;
            codec_sampleorder <= 1'b0;
            codec_i2din       <= '0;
            underrun_cnt      <= '0;
            rx_valid          <= 1'b0;
            rx_data           <= '0;
            rx_chan           <= 1'b0;
        end else begin
            codec_enabler <= enabler_d;
            busy          <= busy_d;
            cfg_err       <= cfg_wr && state != IDLE;
            if (cfg_wr && state == IDLE) begin
                codec_sampleres   <= cfg_res;
                codec_clkdiv      <= cfg_div;
                codec_sampleorder <= cfg_swap;
            end
            if (pop) codec_i2din <= empty ? '0 : 32'(head);
            if (pop && empty && underrun_cnt != UNDERRUN_MAX) underrun_cnt <= underrun_cnt + 1'b1;
            rx_valid <= word && !TX;
            if (word && !TX) begin
                rx_data <= 32'(codec_i2dout[DATA_WIDTH-1:0]);
                rx_chan <= codec_lrclk;
            end
        end
    end
endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// tb_i2s_stream_ctrl: directed vector table plus corner-case sequences for both transceiver modes
module tb_i2s_stream_ctrl;
    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic reset, cfg_wr, cfg_swap, start, stop, tx_valid, codec_buffer, codec_lrclk;
    logic [5:0] cfg_res;
    logic [9:0] cfg_div;
    logic [31:0] tx_data, codec_i2dout;
    logic cfg_err, tx_ready, rx_valid, rx_chan, busy, codec_sampleorder, codec_enabler;
    logic [31:0] rx_data, codec_i2din;
    logic [7:0] underrun_cnt;
    logic [5:0] codec_sampleres;
    logic [9:0] codec_clkdiv;

    logic reset1, start1, buffer1, lrclk1;
    logic [31:0] i2dout1;
    logic cfg_err1, tx_ready1, rx_valid1, rx_chan1, busy1, order1, en1;
    logic [31:0] rx_data1, i2din1;
    logic [7:0] ur1;
    logic [5:0] res1;
    logic [9:0] div1;

    i2s_stream_ctrl #(.TRANSCEIVER_MODE(0)) dut0 (
        .sysclk(sysclk), .reset(reset), .cfg_wr(cfg_wr), .cfg_res(cfg_res), .cfg_div(cfg_div),
        .cfg_swap(cfg_swap), .cfg_err(cfg_err), .start(start), .stop(stop), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_chan(rx_chan), .busy(busy), .underrun_cnt(underrun_cnt),
        .codec_sampleres(codec_sampleres), .codec_clkdiv(codec_clkdiv),
        .codec_sampleorder(codec_sampleorder), .codec_enabler(codec_enabler),
        .codec_i2din(codec_i2din), .codec_buffer(codec_buffer), .codec_i2dout(codec_i2dout),
        .codec_lrclk(codec_lrclk)
    );

    i2s_stream_ctrl #(.TRANSCEIVER_MODE(1)) dut1 (
        .sysclk(sysclk), .reset(reset1), .cfg_wr(1'b0), .cfg_res(6'd16), .cfg_div(10'd4),
        .cfg_swap(1'b0), .cfg_err(cfg_err1), .start(start1), .stop(1'b0), .tx_valid(1'b0),
        .tx_data(32'd0), .tx_ready(tx_ready1), .rx_valid(rx_valid1), .rx_data(rx_data1),
        .rx_chan(rx_chan1), .busy(busy1), .underrun_cnt(ur1),
        .codec_sampleres(res1), .codec_clkdiv(div1),
        .codec_sampleorder(order1), .codec_enabler(en1),
        .codec_i2din(i2din1), .codec_buffer(buffer1), .codec_i2dout(i2dout1),
        .codec_lrclk(lrclk1)
    );

    typedef struct {
        logic cfg_wr; logic [5:0] res; logic start, stop, valid; logic [31:0] data; logic pulse;
        logic en, rdy; logic [31:0] din; logic busy; logic [7:0] ur; logic [5:0] sres; logic err;
    } vec_t;

    int checks = 0, errors = 0;

    function automatic vec_t mk(int cw, int res, int st, int sp, int tv, int td, int pl,
                                int en, int rdy, int din, int bs, int ur, int sr, int er);
        vec_t v;
        v.cfg_wr = cw[0]; v.res = 6'(res); v.start = st[0]; v.stop = sp[0]; v.valid = tv[0];
        v.data = 32'(td); v.pulse = pl[0]; v.en = en[0]; v.rdy = rdy[0]; v.din = 32'(din);
        v.busy = bs[0]; v.ur = 8'(ur); v.sres = 6'(sr); v.err = er[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse;
        codec_buffer = 1'b1;
        tick();
        codec_buffer = 1'b0;
    endtask

    vec_t v [11];

    initial begin
        v[0]  = mk(1, 16, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 16, 0);
        v[1]  = mk(0, 0,  1, 0, 0, 0,      0, 0, 1, 0,      1, 0, 16, 0);
        v[2]  = mk(0, 0,  0, 0, 1, 'h1111, 0, 0, 1, 0,      1, 0, 16, 0);
        v[3]  = mk(0, 0,  0, 0, 1, 'h2222, 0, 0, 1, 0,      1, 0, 16, 0);
        v[4]  = mk(0, 0,  0, 0, 0, 0,      0, 1, 1, 0,      1, 0, 16, 0);
        v[5]  = mk(0, 0,  0, 0, 0, 0,      1, 1, 1, 'h1111, 1, 0, 16, 0);
        v[6]  = mk(0, 0,  0, 0, 0, 0,      0, 1, 1, 'h1111, 1, 0, 16, 0);
        v[7]  = mk(0, 0,  0, 0, 0, 0,      1, 1, 1, 'h2222, 1, 0, 16, 0);
        v[8]  = mk(0, 0,  0, 0, 0, 0,      1, 1, 1, 0,      1, 1, 16, 0);
        v[9]  = mk(1, 24, 0, 0, 0, 0,      0, 1, 1, 0,      1, 1, 16, 1);
        v[10] = mk(0, 0,  0, 0, 0, 0,      0, 1, 1, 0,      1, 1, 16, 0);

        reset = 1'b0; cfg_wr = 1'b0; cfg_res = 6'd0; cfg_div = 10'd4; cfg_swap = 1'b0;
        start = 1'b0; stop = 1'b0; tx_valid = 1'b0; tx_data = '0;
        codec_buffer = 1'b0; codec_i2dout = '0; codec_lrclk = 1'b0;
        reset1 = 1'b0; start1 = 1'b0; buffer1 = 1'b0; i2dout1 = '0; lrclk1 = 1'b0;
        repeat (3) tick();
        chk("rst_enabler", 32'(codec_enabler), 0);
        chk("rst_i2din", codec_i2din, 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun_cnt), 0);
        chk("rst_res", 32'(codec_sampleres), 16);
        chk("rst_div", 32'(codec_clkdiv), 4);
        chk("rst_swap", 32'(codec_sampleorder), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            cfg_wr = v[i].cfg_wr; cfg_res = v[i].res; start = v[i].start; stop = v[i].stop;
            tx_valid = v[i].valid; tx_data = v[i].data; codec_buffer = v[i].pulse;
            tick();
            cfg_wr = 1'b0; start = 1'b0; stop = 1'b0; tx_valid = 1'b0; codec_buffer = 1'b0;
            chk($sformatf("v%0d_enabler", i), 32'(codec_enabler), 32'(v[i].en));
            chk($sformatf("v%0d_tx_ready", i), 32'(tx_ready), 32'(v[i].rdy));
            chk($sformatf("v%0d_i2din", i), codec_i2din, v[i].din);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v[i].busy));
            chk($sformatf("v%0d_underrun", i), 32'(underrun_cnt), 32'(v[i].ur));
            chk($sformatf("v%0d_res", i), 32'(codec_sampleres), 32'(v[i].sres));
            chk($sformatf("v%0d_cfg_err", i), 32'(cfg_err), 32'(v[i].err));
        end

        // underrun counter saturation
        repeat (253) pulse();
        chk("underrun_254", 32'(underrun_cnt), 254);
        repeat (47) pulse();
        chk("underrun_sat", 32'(underrun_cnt), 255);
        chk("underrun_i2din", codec_i2din, 0);

        // fill to full, then push+pop together
        tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data = 32'hA1 + 32'(i);
            tick();
        end
        chk("full_tx_ready", 32'(tx_ready), 0);
        tx_data = 32'hBEEF;
        codec_buffer = 1'b1;
        tick();
        codec_buffer = 1'b0; tx_valid = 1'b0;
        chk("full_pop_head", codec_i2din, 32'hA1);
        chk("full_pop_ready", 32'(tx_ready), 1);
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk($sformatf("full_drain%0d", i), codec_i2din, 32'hA2 + 32'(i));
        end
        pulse();
        chk("full_no_overwrite", codec_i2din, 0);

        // stop lands on next word boundary, then quiesce
        tx_valid = 1'b1; tx_data = 32'h5555; tick();
        tx_data = 32'h6666; tick();
        tx_valid = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_enabler", 32'(codec_enabler), 1);
        chk("stop_tx_ready", 32'(tx_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stop_hold%0d", i), 32'(codec_enabler), 1);
        end
        pulse();
        chk("stop_last_word", codec_i2din, 32'h5555);
        chk("quiesce_en0", 32'(codec_enabler), 0);
        chk("quiesce_busy0", 32'(busy), 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("quiesce_en%0d", i), 32'(codec_enabler), 0);
            chk($sformatf("quiesce_busy%0d", i), 32'(busy), 1);
        end
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_enabler", 32'(codec_enabler), 0);

        // IDLE corner cases: start+stop, config write
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", 32'(busy), 0);
        cfg_wr = 1'b1; cfg_res = 6'd24; tick(); cfg_wr = 1'b0;
        chk("idle_cfg_res", 32'(codec_sampleres), 24);
        chk("idle_cfg_err", 32'(cfg_err), 0);

        // restart: leftover 0x6666 must have been flushed
        start = 1'b1; tick(); start = 1'b0;
        tx_valid = 1'b1; tx_data = 32'h7777; tick(); tx_valid = 1'b0;
        tick(); tick();
        chk("flushed_no_enable", 32'(codec_enabler), 0);
        tx_valid = 1'b1; tx_data = 32'h8888; tick(); tx_valid = 1'b0;
        tick();
        chk("reprime_enable", 32'(codec_enabler), 1);
        pulse();
        chk("reprime_head", codec_i2din, 32'h7777);

        // receive mode
        tick();
        reset1 = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("rx_enabler", 32'(en1), 1);
        chk("rx_tx_ready", 32'(tx_ready1), 0);
        i2dout1 = 32'hABCD; lrclk1 = 1'b1; buffer1 = 1'b1; tick();
        buffer1 = 1'b0; i2dout1 = 32'h1234; lrclk1 = 1'b0;
        chk("rx_valid", 32'(rx_valid1), 1);
        chk("rx_data", rx_data1, 32'hABCD);
        chk("rx_chan", 32'(rx_chan1), 1);
        tick();
        chk("rx_valid_width", 32'(rx_valid1), 0);
        chk("rx_data_hold", rx_data1, 32'hABCD);
        reset1 = 1'b0; tick();
        chk("rx_reset_enabler", 32'(en1), 0);
        chk("rx_reset_busy", 32'(busy1), 0);
        chk("rx_reset_data", rx_data1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
